serial_adder_sched: RTL and testbench
=====================================

Name: serial_adder_sched

Overview:
- Bit-serial add scheduler that time-shares one external 1-bit full adder (full_adder_gp datapath: A, B, Ci -> S, Co) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Accepts an operand pair through a valid/ready input handshake, drives the full adder for WIDTH cycles while registering the carry, then presents sum and carry-out through a valid/ready output handshake.
- Used wherever area matters more than latency. It is the sequencing front-end for the shared adder cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair and cin valid
- in_ready  output  1  scheduler can accept a new operand pair
- op_a  input  WIDTH  addend A
- op_b  input  WIDTH  addend B
- cin  input  1  carry-in for bit 0
- fa_a  output  1  to full adder A
- fa_b  output  1  to full adder B
- fa_ci  output  1  to full adder Ci
- fa_s  input  1  from full adder S
- fa_co  input  1  from full adder Co
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry-out of bit WIDTH-1
- busy  output  1  high in RUN state
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Internal a/b shift registers, carry register and counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch op_a and op_b into shift registers, carry_reg<=cin, cnt<=0, go to RUN.
- RUN:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_ci=carry_reg. These are combinational from registers; the adder path is combinational within the cycle.
  - Each edge: shift a_sh/b_sh right by 1, shift fa_s into sum_sh MSB (sum_sh shifts right), carry_reg<=fa_co, cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: go to DONE, cout<=fa_co.
- DONE:
  - out_valid=1. sum and cout are held stable.
  - On an edge with out_ready=1: go to IDLE.
  - in_ready=0 while in DONE, so a new pair is accepted no earlier than the cycle after the output handshake.
- Outside RUN, fa_a/fa_b/fa_ci are driven 0.
- Latency: accept edge E0. Bit k is processed between E(k) and E(k+1). out_valid rises after edge E(WIDTH).
- Throughput: minimum WIDTH+2 cycles per operation.
- Width rules: sum is WIDTH bits, cout is the true carry-out, and {cout,sum} equals op_a+op_b+cin exactly.
- in_valid while not in_ready is ignored; operands need not be held after the accept edge.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation (any state) returns immediately to IDLE with reset values. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - In RUN at cnt==WIDTH-1, carry_reg (carry into the MSB) is XORed with fa_co and registered into ovf together with cout.
  - ovf is valid with out_valid and held in DONE; ovf=1 exactly when signed two's-complement overflow occurred.
- Not defined: ovf is tied to 0 and the extra logic is absent. The port list is unchanged.

Test Plan:
- WIDTH=8, op_a=0x35, op_b=0x4A, cin=0, out_ready=1 -> out_valid after exactly 8 RUN edges; sum=0x7F, cout=0, busy high for 8 cycles.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Same pair with cin=1 -> sum=0x01, cout=1.
- With SERIAL_ADDER_OVF_EN, op_a=0x7F, op_b=0x01 -> sum=0x80, cout=0, ovf=1; op_a=0x80, op_b=0x80 -> sum=0x00, cout=1, ovf=1. Without the macro, ovf=0 for both.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout stable and in_ready=0 throughout; out_ready=1 -> IDLE, then in_ready=1 next cycle.
- Back-to-back: in_valid held high with two pairs (0x10+0x20, then 0x0F+0x01) -> results 0x30 then 0x10, second accept exactly one cycle after the first output handshake.
- Reset: assert rst_n=0 on the 3rd RUN cycle -> all outputs go to reset values asynchronously; after release, in_ready=1 and no stale out_valid.

Source files
------------

// File: rtl/serial_adder_sched.sv
// Bit-serial add scheduler: sequences one external 1-bit full adder over WIDTH cycles, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_sched #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               run_s;
    logic [WIDTH-1:0]   sum_d;
    logic [WIDTH-1:0]   a_sh_d;
    logic [WIDTH-1:0]   b_sh_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    // Adder operand drive: gated so the shared cell sees zeros outside RUN.
    always_comb begin
        run_s  = (state_q == ST_RUN);
        fa_a   = run_s & a_sh_q[0];
        fa_b   = run_s & b_sh_q[0];
        fa_ci  = run_s & carry_q;
        sum_d  = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
    end

    // Scheduler FSM with all handshake/status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= op_a;
                        b_sh_q     <= op_b;
                        carry_q    <= cin;
                        cnt_q      <= {CNT_W{1'b0}};
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_DONE;
                        cout_q      <= fa_co;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB differing from carry out of it flags signed overflow.
                        ovf_q       <= carry_q ^ fa_co;
`endif
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_sched.sv
// Directed self-checking bench for serial_adder_sched (WIDTH=8) with a behavioural full adder.
module tb_serial_adder_sched;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       cin = 1'b0;
    logic       fa_a, fa_b, fa_ci, fa_s, fa_co;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    serial_adder_sched #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_s(fa_s), .fa_co(fa_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy), .ovf(ovf)
    );

    // External shared full adder cell.
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int hold, input logic [7:0] es, input logic ec, input logic eo_hand);
        int  n;
        int  nb;
        logic eo;
        eo = OVF_ON ? eo_hand : 1'b0;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check_val({tag, "_rdy"}, 64'(in_ready), 64'd1);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
        check_val({tag, "_fa_bit0"}, {61'd0, fa_a, fa_b, fa_ci}, {61'd0, a[0], b[0], c});
        n = 0; nb = 0;
        while (!out_valid && n < 30) begin
            if (busy) nb++;
            tick();
            n++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'd8);
        check_val({tag, "_busy_cycles"}, 64'(nb), 64'd8);
        check_val({tag, "_sum"}, 64'(sum), 64'(es));
        check_val({tag, "_cout"}, 64'(cout), 64'(ec));
        check_val({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check_val({tag, "_idle_fa"}, {61'd0, fa_a, fa_b, fa_ci}, 64'd0);
        check_val({tag, "_rdy_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_val({tag, "_hold_sum"}, {55'd0, out_valid, cout, sum}, {55'd0, 1'b1, ec, es});
            check_val({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check_val({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", {58'd0, in_ready, out_valid, busy, cout, ovf, fa_a}, {58'd0, 6'b100000});
        check_val("rst_sum", 64'(sum), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        run_op("v35_4a", 8'h35, 8'h4A, 1'b0, 0, 8'h7F, 1'b0, 1'b0);
        run_op("vff_01", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_op("vff_01c", 8'hFF, 8'h01, 1'b1, 0, 8'h01, 1'b1, 1'b0);
        run_op("v7f_01", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_op("v80_80", 8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        run_op("bp_c3_99", 8'hC3, 8'h99, 1'b0, 5, 8'h5C, 1'b1, 1'b1);

        // Back-to-back with in_valid held high across both pairs.
        out_ready = 1'b1;
        op_a = 8'h10; op_b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        tick();
        op_a = 8'h0F; op_b = 8'h01;
        check_val("b2b_first_acc", 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check_val("b2b_lat1", 64'(n), 64'd8);
        check_val("b2b_sum1", {55'd0, cout, sum}, {55'd0, 9'h030});
        tick();
        check_val("b2b_hs_idle", {62'd0, in_ready, busy}, {62'd0, 2'b10});
        tick();
        in_valid = 1'b0;
        check_val("b2b_second_acc", {62'd0, in_ready, busy}, {62'd0, 2'b01});
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check_val("b2b_lat2", 64'(n), 64'd8);
        check_val("b2b_sum2", {55'd0, cout, sum}, {55'd0, 9'h010});
        tick();

        // Asynchronous reset during the third RUN cycle.
        op_a = 8'h35; op_b = 8'h4A; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check_val("mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_state", {58'd0, in_ready, out_valid, busy, cout, ovf, fa_a}, {58'd0, 6'b100000});
        check_val("mid_rst_sum", 64'(sum), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("post_rst_idle", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
